// File: rtl/pc_fetch.sv
// Program counter owner and single-outstanding instruction fetch handshake (RST -> FETCH -> DELIVER -> ...).
// Optional fetch timeout is built when FETCH_TIMEOUT_EN is defined; otherwise fetch_err is tied low.
module pc_fetch #(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_next,
    output logic [15:0] pc_cur,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_accept,
    input  logic        hlt_in,
    output logic        halted,
    output logic        fetch_err
);

    localparam logic [1:0] ST_RST     = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_DELIVER = 2'd2;
    localparam logic [1:0] ST_HALT    = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout_hit;

    // The count reached on this edge, not the stored one, decides the timeout.
    assign timeout_hit = (32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        halted_d = halted_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        case (state_q)
            ST_RST: begin
                state_d = ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_data;
                    valid_d = 1'b1;
                    state_d = ST_DELIVER;
                end else begin
`ifdef FETCH_TIMEOUT_EN
                    if (timeout_hit) begin
                        err_d    = 1'b1;
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end else begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
`endif
                end
            end
            ST_DELIVER: begin
                if (instr_accept) begin
                    valid_d = 1'b0;
                    if (hlt_in) begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end else begin
                        pc_d    = pc_next;
                        state_d = ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            default: begin
                // HALT is terminal until reset.
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RST;
            pc_q     <= RESET_PC;
            instr_q  <= 16'h0000;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = pc_q;
    assign pc_cur      = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;

endmodule
